// File: rtl/add32_seq_ctrl.sv
// add32_seq_ctrl: 32-bit add/subtract sequencer for the multi-cycle ALU.
// One 16-bit adder slice (bit16Adder) is time-shared over two cycles:
// the low half first, then the high half using the registered carry.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          synchronous active-high reset
//   start        request, accepted only while ready=1
//   sub          0 = a+b, 1 = a-b (sampled with start)
//   a, b         32-bit operands (sampled with start)
//   ready        high only in IDLE
//   result       32-bit sum/difference, qualified by result_valid
//   carry        carry out of bit 31 (for subtract: 1 = no borrow)
//   overflow     signed two's-complement overflow
//   zero         result == 0
//   result_valid result/flags valid, held until acknowledged
//   result_ack   consumer accepts the result while result_valid=1
//   op_count     count of acknowledged operations, wraps modulo 2^CNT_W

// bit16Adder: the shared 16-bit ripple slice with carry in and carry out.
module bit16Adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  // 17-bit add so the carry out falls into the top bit.
  always_comb begin
    {c_out, sum} = {1'b0, a} + {1'b0, b} + {16'd0, c_in};
  end

endmodule

module add32_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             ready,
  output logic [31:0]      result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             result_valid,
  input  logic             result_ack,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        cin_r;
  logic        c_mid;
  logic [15:0] slice_a;
  logic [15:0] slice_b;
  logic        slice_cin;
  logic [15:0] slice_sum;
  logic        slice_cout;

  bit16Adder u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (slice_cin),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: fixed LO -> HI -> DONE walk, leaving DONE on ack.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LO;
      LO:   next_state = HI;
      HI:   next_state = DONE;
      DONE: if (result_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/steering logic: handshake flags and the adder slice input mux.
  // The slice sees the upper halves and the stored mid carry only in HI.
  always_comb begin
    ready        = (state == IDLE);
    result_valid = (state == DONE);
    if (state == HI) begin
      slice_a   = a_r[31:16];
      slice_b   = b_r[31:16];
      slice_cin = c_mid;
    end else begin
      slice_a   = a_r[15:0];
      slice_b   = b_r[15:0];
      slice_cin = cin_r;
    end
  end

  // Datapath: operand capture (subtract as a + ~b + 1), half-results and
  // flags. Result and flags persist after ack until the next LO/HI.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      cin_r    <= 1'b0;
      c_mid    <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            cin_r <= sub;
          end
        end
        LO: begin
          result[15:0] <= slice_sum;
          c_mid        <= slice_cout;
        end
        HI: begin
          result[31:16] <= slice_sum;
          carry         <= slice_cout;
          overflow      <= (a_r[31] == b_r[31]) && (slice_sum[15] != a_r[31]);
          zero          <= ({slice_sum, result[15:0]} == 32'd0);
        end
        DONE: begin
          if (result_ack) op_count <= op_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add32_seq_ctrl.sv
// tb_add32_seq_ctrl: directed, table-driven bench for add32_seq_ctrl.
// The DUT is built with CNT_W=2 so the op_count wrap is reachable quickly;
// expected counts are therefore tracked modulo 4.
module tb_add32_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic [31:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        result_valid;
  logic        result_ack;
  logic [1:0]  op_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vsub;
    logic [31:0] exp_result;
    logic        exp_carry;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[9];

  add32_seq_ctrl #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sub          (sub),
    .a            (a),
    .b            (b),
    .ready        (ready),
    .result       (result),
    .carry        (carry),
    .overflow     (overflow),
    .zero         (zero),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .op_count     (op_count)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one request from IDLE and returns the number of clock edges,
  // counting the accepting edge, until result_valid is seen (capped at 10).
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input logic s, output int lat);
    a     = av;
    b     = bv;
    sub   = s;
    start = 1'b1;
    lat   = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (result_valid) break;
    end
  endtask

  // Single-cycle ack pulse, sampled 1 unit after the edge.
  task automatic ackOnce();
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
  endtask

  // Main sequence: reset, vector table, handshake corners, reset, wrap.
  initial begin
    logic [1:0] exp_count;
    int         lat;
    int         cyc;
    int         last;
    int         k;

    vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h00000003, 32'h00000007, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; result_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_valid", 32'(result_valid), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_flags", {29'd0, carry, overflow, zero}, 32'd0);
    checkOutput("reset_count", 32'(op_count), 32'd0);
    exp_count = 2'd0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vsub, lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      checkOutput($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      checkOutput($sformatf("v%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
      checkOutput($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      checkOutput($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
      ackOnce();
      exp_count = exp_count + 2'd1;
      checkOutput($sformatf("v%0d_ready_after_ack", i), 32'(ready), 32'd1);
      checkOutput($sformatf("v%0d_valid_after_ack", i), 32'(result_valid), 32'd0);
      checkOutput($sformatf("v%0d_count", i), 32'(op_count), 32'(exp_count));
    end

    // Ack while idle must not count.
    ackOnce();
    checkOutput("idle_ack_count", 32'(op_count), 32'(exp_count));
    checkOutput("idle_ack_ready", 32'(ready), 32'd1);

    // Stall in DONE for 5 cycles with competing start requests.
    applyStimulus(32'd1, 32'd2, 1'b0, lat);
    checkOutput("stall_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; a = 32'hFFFFFFFF; b = 32'h00000001; sub = 1'b0;
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d_valid", i), 32'(result_valid), 32'd1);
      checkOutput($sformatf("stall%0d_result", i), result, 32'd3);
      checkOutput($sformatf("stall%0d_flags", i), {29'd0, carry, overflow, zero}, 32'd0);
      checkOutput($sformatf("stall%0d_ready", i), 32'(ready), 32'd0);
    end
    start = 1'b0;
    ackOnce();
    exp_count = exp_count + 2'd1;
    checkOutput("stall_ack_ready", 32'(ready), 32'd1);
    checkOutput("stall_ack_count", 32'(op_count), 32'(exp_count));
    checkOutput("stall_result_persists", result, 32'd3);
    @(posedge clk); #1;
    checkOutput("stall_start_not_queued", 32'(ready), 32'd1);

    // Reset during HI: ack is also held high to show reset wins.
    a = 32'h12345678; b = 32'h00000001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; result_ack = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; result_ack = 1'b0;
    checkOutput("midrst_ready", 32'(ready), 32'd1);
    checkOutput("midrst_valid", 32'(result_valid), 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_flags", {29'd0, carry, overflow, zero}, 32'd0);
    checkOutput("midrst_count", 32'(op_count), 32'd0);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (result_valid || !ready) k++;
    end
    checkOutput("midrst_no_stale_result", 32'(k), 32'd0);

    // Counter wrap: start and ack tied high, four back-to-back ops.
    a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1; result_ack = 1'b1;
    cyc = 0; last = 0; k = 0;
    while (k < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) begin
        k++;
        checkOutput($sformatf("wrap%0d_count", k), 32'(op_count), 32'(k % 4));
        checkOutput($sformatf("wrap%0d_interval", k), 32'(cyc - last), 32'd4);
        last = cyc;
      end
    end
    checkOutput("wrap_completed", 32'(k), 32'd4);
    start = 1'b0; result_ack = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add32_seq_ctrl.md
Name: add32_seq_ctrl

Overview:
- Sequencer that performs a 32-bit add/subtract for the ALU by time-sharing one instance of the team's 16-bit adder (bit16Adder) over two cycles: low half first, then high half with the registered carry.
- Uses a start/ready request and result_valid/result_ack handshake.
- Sits between the multi-cycle ALU issue logic and the adder slice.
- Produces MIPS-relevant flags: carry, signed overflow and zero.

Parameters:
- CNT_W, 16, width of the completed-operation counter op_count (wraps modulo 2^CNT_W)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  32  operand A; sampled with start
- b  input  32  operand B; sampled with start
- ready  output  1  high only in IDLE
- result  output  32  sum/difference; valid while result_valid=1
- carry  output  1  carry out of bit 31 (for sub: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  result == 0
- result_valid  output  1  result/flags valid, held until acknowledged
- result_ack  input  1  consumer accepts result when result_valid=1
- op_count  output  CNT_W  number of completed (acknowledged) operations

Behaviour:
- Reset (rst=1 at a rising edge, any state):
  - state=IDLE; ready=1; result=0; carry=0; overflow=0; zero=0; result_valid=0; op_count=0.
  - Internal operand and carry registers are cleared.
  - Any in-flight operation is abandoned with no result produced.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - ready=1.
  - If start=1: capture a_r=a, b_r=(sub ? ~b : b), cin_r=sub, then go to LO.
  - Otherwise stay in IDLE.
- LO:
  - Adder inputs a_r[15:0], b_r[15:0], c_in=cin_r.
  - Register sum into result[15:0] and the slice carry-out into c_mid.
  - Go to HI.
- HI:
  - Adder inputs a_r[31:16], b_r[31:16], c_in=c_mid.
  - Register sum into result[31:16] and carry=c_out.
  - overflow = (a_r[31]==b_r[31]) && (sum[15]!=a_r[31]).
  - zero = ({sum, result[15:0]} == 0).
  - Set result_valid=1; go to DONE.
- DONE:
  - result, flags and result_valid held stable.
  - If result_ack=1: clear result_valid, op_count += 1 (wraps), go to IDLE.
  - result_ack in the first DONE cycle is legal.
- Latency:
  - start sampled at the end of cycle N.
  - result_valid=1 from cycle N+3.
  - With result_ack tied high: ready=1 again in cycle N+4, giving a 4-cycle minimum issue interval.
- Handshake and boundary rules:
  - start while ready=0 is ignored; it is not queued, and operand inputs are don't-care.
  - result_ack while result_valid=0 is ignored, including in IDLE, LO and HI.
  - result, carry, overflow and zero persist after ack until overwritten in the next LO/HI; only result_valid qualifies them.
  - LO writes result[15:0] while result_valid=0, so intermediate values are never flagged valid.
  - Arithmetic is modulo 2^32 with no saturation; the carry from the 32-bit add is dropped into carry only.
  - op_count at 2^CNT_W-1 wraps to 0 on the next ack.
  - rst has priority over start and result_ack in the same cycle.

Test Plan:
- Add with cross-half carry:
  - Stimulus: a=0x0000FFFF, b=0x00000001, sub=0.
  - Required: result=0x00010000, carry=0, overflow=0, zero=0, result_valid asserted exactly 3 cycles after start.
- Signed overflow:
  - Stimulus: a=0x7FFFFFFF, b=0x00000001, sub=0.
  - Required: result=0x80000000, overflow=1, carry=0.
  - Stimulus: a=0xFFFFFFFF, b=0x00000001, sub=0.
  - Required: result=0, carry=1, zero=1, overflow=0.
- Subtract:
  - Stimulus: a=5, b=5, sub=1.
  - Required: result=0, zero=1, carry=1, overflow=0.
  - Stimulus: a=0, b=1, sub=1.
  - Required: result=0xFFFFFFFF, carry=0, overflow=0.
  - Stimulus: a=0x80000000, b=1, sub=1.
  - Required: result=0x7FFFFFFF, overflow=1.
- Handshake:
  - Stimulus: hold result_ack=0 for 5 cycles in DONE, asserting start with new operands during that time.
  - Required: result, flags and result_valid are stable and the new start is ignored; ack then gives ready=1 the next cycle and op_count+1.
- Reset mid-operation:
  - Stimulus: assert rst during HI.
  - Required: next cycle state=IDLE, ready=1, result_valid=0, outputs 0, op_count=0, and no stale result appears afterwards.
- Counter wrap:
  - Stimulus: CNT_W=2, four acknowledged back-to-back ops with result_ack tied high.
  - Required: op_count sequence 1,2,3,0, with ready re-asserted every 4 cycles.
